// File: rtl/conv1d_mac_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : conv1d_mac_sched_pkg
// Brief   : Shared data width and scheduler state encoding for conv1d controllers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv1d_mac_sched_pkg;

    localparam int WIDTH_DATA = 8;
    localparam int PSUM_W     = 2 * WIDTH_DATA;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACC   = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/conv1d_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : conv1d_addr_gen
// Brief   : Output (n) and tap (k) counters with weight/feature read addresses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv1d_addr_gen
    import conv1d_mac_sched_pkg::*;
#(
    parameter int KERNEL_LEN = 3,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] in_len,
    input  logic              k_inc,
    input  logic              next_out,
    input  logic              look_ahead,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] f_addr,
    output logic [ADDR_W-1:0] n_idx,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last_out
);

    localparam logic [ADDR_W-1:0] KL     = ADDR_W'(KERNEL_LEN);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KERNEL_LEN - 1);

    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] k_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            n   <= '0;
            k   <= '0;
            len <= '0;
        end else if (load) begin
            n   <= '0;
            k   <= '0;
            len <= in_len;
        end else if (next_out) begin
            n   <= n + 1'b1;
            k   <= '0;
        end else if (k_inc) begin
            k   <= k + 1'b1;
        end
    end

    // While accumulating tap k, the read for tap k+1 is already in flight.
    assign k_rd      = k + {{(ADDR_W-1){1'b0}}, look_ahead};
    assign w_addr    = k_rd;
    assign f_addr    = n + k_rd;
    assign n_idx     = n;
    assign first_tap = (k == '0);
    assign last_tap  = (k == K_LAST);
    assign last_out  = (n == len - KL);

endmodule

`default_nettype wire

// File: rtl/conv1d_mac_sched.sv
//------------------------------------------------------------------------------
// Module  : conv1d_mac_sched
// Brief   : Schedules an external MAC for 1-D valid-mode correlation over SRAM
//           operands. Optional ReLU on the output stream via CONV1D_RELU_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv1d_mac_sched
    import conv1d_mac_sched_pkg::*;
#(
    parameter int KERNEL_LEN = 3,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cfg_in_len,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [ADDR_W-1:0]     f_addr,
    output logic                  rd_en,
    input  logic [WIDTH_DATA-1:0] w_data,
    input  logic [WIDTH_DATA-1:0] f_data,
    output logic [WIDTH_DATA-1:0] mac_weight,
    output logic [WIDTH_DATA-1:0] mac_feature,
    output logic [PSUM_W-1:0]     mac_psum_in,
    input  logic [PSUM_W-1:0]     mac_psum_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_W-1:0]     out_data,
    output logic [ADDR_W-1:0]     out_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_W-1:0] KL = ADDR_W'(KERNEL_LEN);

    state_t            state;
    state_t            state_nxt;
    logic [PSUM_W-1:0] acc;
    logic              load;
    logic              k_inc;
    logic              next_out;
    logic              look_ahead;
    logic              err_set;
    logic              first_tap;
    logic              last_tap;
    logic              last_out;

    conv1d_addr_gen #(
        .KERNEL_LEN (KERNEL_LEN),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .in_len     (cfg_in_len),
        .k_inc      (k_inc),
        .next_out   (next_out),
        .look_ahead (look_ahead),
        .w_addr     (w_addr),
        .f_addr     (f_addr),
        .n_idx      (out_idx),
        .first_tap  (first_tap),
        .last_tap   (last_tap),
        .last_out   (last_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_set;
            if (state == S_ACC) begin
                acc <= mac_psum_out;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        look_ahead = 1'b0;
        k_inc      = 1'b0;
        next_out   = 1'b0;
        load       = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_in_len >= KL) begin
                        load      = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        err_set   = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                if (last_tap) begin
                    state_nxt  = S_OUT;
                end else begin
                    rd_en      = 1'b1;
                    look_ahead = 1'b1;
                    k_inc      = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_out) begin
                        state_nxt = S_FIN;
                    end else begin
                        next_out  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign mac_weight  = w_data;
    assign mac_feature = f_data;
    assign mac_psum_in = ((state == S_ACC) && !first_tap) ? acc : '0;
    assign out_valid   = (state == S_OUT);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FIN);

`ifdef CONV1D_RELU_EN
    // Clamp only the streamed value; the accumulator keeps its signed result.
    assign out_data = acc[PSUM_W-1] ? '0 : acc;
`else
    assign out_data = acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv1d_mac_sched.sv
// Self-checking bench for conv1d_mac_sched: vector table, hand sequences and
// randomized jobs checked against a plain-arithmetic correlation model.
`default_nettype none

module tb_conv1d_mac_sched;

`ifdef CONV1D_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_in_len;
    logic [7:0]  w_addr;
    logic [7:0]  f_addr;
    logic        rd_en;
    logic [7:0]  w_data;
    logic [7:0]  f_data;
    logic [7:0]  mac_weight;
    logic [7:0]  mac_feature;
    logic [15:0] mac_psum_in;
    logic [15:0] mac_psum_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_idx;
    logic        busy;
    logic        done;
    logic        err;

    conv1d_mac_sched #(.KERNEL_LEN(3), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_in_len   (cfg_in_len),
        .w_addr       (w_addr),
        .f_addr       (f_addr),
        .rd_en        (rd_en),
        .w_data       (w_data),
        .f_data       (f_data),
        .mac_weight   (mac_weight),
        .mac_feature  (mac_feature),
        .mac_psum_in  (mac_psum_in),
        .mac_psum_out (mac_psum_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // SRAM models (1-cycle synchronous read) and the external MAC
    logic [7:0] wmem [256];
    logic [7:0] fmem [256];

    always @(posedge clk) begin
        if (rst) begin
            w_data <= 8'd0;
            f_data <= 8'd0;
        end else if (rd_en) begin
            w_data <= wmem[w_addr];
            f_data <= fmem[f_addr];
        end
    end

    assign mac_psum_out = mac_psum_in + (16'($signed(mac_weight)) * 16'($signed(mac_feature)));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu16(input logic [15:0] x);
        return (RELU && x[15]) ? 16'd0 : x;
    endfunction

    // y[n] = sum_k w[k]*f[n+k], wrapped to 16 bits
    function automatic logic [15:0] ref_y(input int n);
        int s = 0;
        for (int k = 0; k < 3; k++) begin
            s += int'($signed(wmem[k])) * int'($signed(fmem[n + k]));
        end
        return relu16(s[15:0]);
    endfunction

    typedef struct packed {
        logic [2:0][7:0]  w;
        logic [7:0][7:0]  f;
        logic [7:0]       len;
        logic [3:0]       bp;
        logic [3:0]       nexp;
        logic [5:0][15:0] y;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic [23:0] w, input logic [63:0] f,
                           input logic [7:0] len, input logic [3:0] bp,
                           input logic [3:0] nexp, input logic [95:0] y);
        vecs[i].w    = w;
        vecs[i].f    = f;
        vecs[i].len  = len;
        vecs[i].bp   = bp;
        vecs[i].nexp = nexp;
        vecs[i].y    = y;
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'd0;
            fmem[i] = 8'd0;
        end
        for (int k = 0; k < 3; k++) wmem[k] = v.w[k];
        for (int i = 0; i < 8; i++) fmem[i] = v.f[i];
    endtask

    logic [15:0] got_d [$];
    logic [7:0]  got_i [$];

    // Runs one job, draining results with bp cycles of backpressure each.
    task automatic run_job(input logic [7:0] len, input int bp, input bit poke,
                           output bit saw_done, output bit saw_err, output bit saw_valid);
        bit          holding;
        bit          fin;
        bit          poked;
        int          wait_c;
        logic [15:0] hd;
        logic [7:0]  hi;
        got_d.delete();
        got_i.delete();
        saw_done = 0; saw_err = 0; saw_valid = 0;
        holding = 0; fin = 0; poked = 0; wait_c = 0; hd = '0; hi = '0;
        @(negedge clk);
        start = 1'b1; cfg_in_len = len;
        @(negedge clk);
        start = 1'b0; cfg_in_len = 8'($urandom);
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (err) saw_err = 1;
            if (done) begin
                saw_done = 1;
                fin = 1;
            end else if (!busy && c > 3) begin
                fin = 1;
            end else begin
                start = 1'b0;
                if (out_valid) begin
                    saw_valid = 1;
                    if (!holding) begin
                        holding = 1; hd = out_data; hi = out_idx; wait_c = 0;
                    end else begin
                        check("hold_data", 32'(out_data), 32'(hd));
                        check("hold_idx", 32'(out_idx), 32'(hi));
                    end
                    if (poke && !poked) begin
                        start = 1'b1; cfg_in_len = 8'd3; poked = 1;
                    end
                    out_ready = (wait_c >= bp);
                    if (out_ready) begin
                        got_d.push_back(out_data);
                        got_i.push_back(out_idx);
                        holding = 0;
                    end
                    wait_c++;
                end else begin
                    out_ready = 1'b0;
                end
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        start = 1'b0;
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL job_timeout: got no completion expected done within 3000 cycles");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sd, se, sv;
        bit bad_seen;
        int len, nexp;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; cfg_in_len = 8'd0;
        set_vec(0, 24'h030201, 64'h0000000504030201, 8'd5, 4'd0, 4'd3, 96'h0000_0000_0000_001A_0014_000E);
        set_vec(1, 24'h030201, 64'h0000000504030201, 8'd5, 4'd5, 4'd3, 96'h0000_0000_0000_001A_0014_000E);
        set_vec(2, 24'hFFFFFF, 64'h0000000504030201, 8'd5, 4'd1, 4'd3, 96'h0000_0000_0000_FFF4_FFF7_FFFA);
        set_vec(3, 24'h030201, 64'h0000000504030201, 8'd2, 4'd0, 4'd0, 96'h0);
        set_vec(4, 24'h030201, 64'h0000000504030201, 8'd3, 4'd0, 4'd1, 96'h0000_0000_0000_0000_0000_000E);
        set_vec(5, 24'h808080, 64'h0000000000808080, 8'd3, 4'd0, 4'd1, 96'h0000_0000_0000_0000_0000_C000);
        set_vec(6, 24'hFF0002, 64'h0000CE640007FD05, 8'd6, 4'd2, 4'd4, 96'h0000_0000_0032_FFAA_FFFA_0003);
        load_vec(vecs[0]);

        repeat (3) @(negedge clk);
        check("rst_flags", {27'd0, busy, out_valid, done, err, rd_en}, 32'd0);
        check("rst_addr", {16'd0, w_addr, f_addr}, 32'd0);
        check("rst_out", {8'd0, out_data, out_idx}, 32'd0);
        check("rst_psum", 32'(mac_psum_in), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            load_vec(vecs[v]);
            run_job(vecs[v].len, int'(vecs[v].bp), 1'b0, sd, se, sv);
            check($sformatf("v%0d_err", v), 32'(se), 32'(vecs[v].nexp == 0));
            check($sformatf("v%0d_done", v), 32'(sd), 32'(vecs[v].nexp != 0));
            check($sformatf("v%0d_valid", v), 32'(sv), 32'(vecs[v].nexp != 0));
            check($sformatf("v%0d_count", v), 32'(got_d.size()), 32'(vecs[v].nexp));
            for (int i = 0; i < int'(vecs[v].nexp) && i < got_d.size(); i++) begin
                check($sformatf("v%0d_data%0d", v, i), 32'(got_d[i]), 32'(relu16(vecs[v].y[i])));
                check($sformatf("v%0d_idx%0d", v, i), 32'(got_i[i]), i);
            end
        end

        // Latency, look-ahead addressing, psum feedback, then reset during ACC
        load_vec(vecs[0]);
        @(negedge clk); start = 1'b1; cfg_in_len = 8'd5;
        @(negedge clk); start = 1'b0;
        check("fetch_rd", {29'd0, rd_en, busy, out_valid}, 32'b110);
        check("fetch_addr", {16'd0, w_addr, f_addr}, 32'h0000);
        @(negedge clk);
        check("acc0_psum", 32'(mac_psum_in), 32'd0);
        check("acc0_addr", {15'd0, rd_en, w_addr, f_addr}, 32'h10101);
        @(negedge clk);
        check("acc1_psum", 32'(mac_psum_in), 32'd1);
        check("acc1_addr", {15'd0, rd_en, w_addr, f_addr}, 32'h10202);
        @(negedge clk);
        check("acc2_psum", 32'(mac_psum_in), 32'd5);
        check("acc2_novalid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", {8'd0, out_data, out_idx}, {8'd0, 16'd14, 8'd0});
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("next_fetch", {15'd0, rd_en, w_addr, f_addr}, 32'h10001);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_idle", {30'd0, busy, out_valid}, 32'd0);
        bad_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || err || out_valid || busy) bad_seen = 1;
        end
        check("midrst_quiet", 32'(bad_seen), 32'd0);

        // Rerun after reset, with a start pulse injected during OUT
        run_job(8'd5, 2, 1'b1, sd, se, sv);
        check("rerun_count", 32'(got_d.size()), 32'd3);
        check("rerun_done", 32'(sd), 32'd1);
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            check($sformatf("rerun_data%0d", i), 32'(got_d[i]), 32'(relu16(vecs[0].y[i])));
        end
        @(negedge clk);
        check("poke_ignored", 32'(busy), 32'd0);

        // Randomized jobs against the correlation model
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) begin
                wmem[i] = 8'($urandom);
                fmem[i] = 8'($urandom);
            end
            len  = (t % 6 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 20));
            nexp = (len >= 3) ? len - 2 : 0;
            run_job(8'(len), int'($urandom_range(0, 2)), 1'b0, sd, se, sv);
            check($sformatf("r%0d_count", t), 32'(got_d.size()), 32'(nexp));
            check($sformatf("r%0d_err", t), 32'(se), 32'(len < 3));
            check($sformatf("r%0d_done", t), 32'(sd), 32'(len >= 3));
            for (int i = 0; i < nexp && i < got_d.size(); i++) begin
                check($sformatf("r%0d_data%0d", t, i), 32'(got_d[i]), 32'(ref_y(i)));
                check($sformatf("r%0d_idx%0d", t, i), 32'(got_i[i]), i);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
